// File: rtl/wb_master_lsu.sv
// -----------------------------------------------------------------------------
// wb_master_lsu
//
// Wishbone classic initiator for the CPU load/store unit. It takes one core
// request at a time and turns it into a single Wishbone bus cycle. Byte-lane
// selects come from size and address. Write data is replicated across lanes.
// Read data is zero- or sign-extended.
//
// Optional build macro:
//   WB_TIMEOUT_EN  - enables a bus-cycle watchdog of TIMEOUT_CYCLES cycles.
//                    When undefined, BUS waits forever and rsp_timeout_o is 0.
//
// Parameters:
//   XLEN            data/address width (lane logic assumes 32)
//   TIMEOUT_CYCLES  watchdog limit, only meaningful with WB_TIMEOUT_EN
//
// Ports:
//   clk_i, rst_i       clock (rising edge), synchronous active-low reset
//   req_valid_i        core request strobe
//   req_ready_o        high when idle and able to accept a request
//   req_we_i           1 = store, 0 = load
//   req_addr_i         byte address
//   req_size_i         00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i     zero-extend the load result when set
//   req_wdata_i        right-justified store data
//   rsp_valid_o        one-cycle response pulse
//   rsp_rdata_o        extended load data (0 on store or error)
//   rsp_err_o          bus error, misalignment, illegal size or timeout
//   rsp_timeout_o      response was produced by the watchdog
//   adr_o              word address
//   dat_o / dat_i      write / read data
//   sel_o              byte-lane select
//   we_o, cyc_o, stb_o Wishbone cycle controls
//   ack_i, err_i       slave acknowledge / error
// -----------------------------------------------------------------------------
module wb_master_lsu #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [1:0]      req_size_i,
    input  logic            req_unsigned_i,
    input  logic [XLEN-1:0] req_wdata_i,

    output logic            rsp_valid_o,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic            rsp_err_o,
    output logic            rsp_timeout_o,

    output logic [XLEN-3:0] adr_o,
    output logic [XLEN-1:0] dat_o,
    input  logic [XLEN-1:0] dat_i,
    output logic [3:0]      sel_o,
    output logic            we_o,
    output logic            cyc_o,
    output logic            stb_o,
    input  logic            ack_i,
    input  logic            err_i
);

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t          state_q, state_d;

    logic [XLEN-3:0] adr_d;
    logic [XLEN-1:0] dat_d;
    logic [3:0]      sel_d;
    logic            we_d;
    logic            cyc_d;
    logic            stb_d;
    logic            rsp_valid_d;
    logic [XLEN-1:0] rsp_rdata_d;
    logic            rsp_err_d;
    logic            rsp_timeout_d;

    // Request context kept for the read-data extension on the ack edge.
    logic [1:0]      size_q, size_d;
    logic            unsigned_q, unsigned_d;

    logic            req_illegal;
    logic [3:0]      req_sel;
    logic [XLEN-1:0] req_dat;
    logic [XLEN-1:0] load_data;
    logic            timeout_hit;

    assign req_ready_o = (state_q == IDLE);

    // Sign/zero extension of right-justified sub-word read data.
    function automatic logic [XLEN-1:0] extend_load(
        input logic [1:0]      size,
        input logic            is_unsigned,
        input logic [XLEN-1:0] data
    );
        logic [XLEN-1:0] result;
        case (size)
            SizeByte: result = {{(XLEN-8){~is_unsigned & data[7]}}, data[7:0]};
            SizeHalf: result = {{(XLEN-16){~is_unsigned & data[15]}}, data[15:0]};
            default:  result = data;
        endcase
        return result;
    endfunction

    // Misaligned halves/words and the reserved size never reach the bus.
    always_comb begin
        req_illegal = 1'b0;
        case (req_size_i)
            SizeByte: req_illegal = 1'b0;
            SizeHalf: req_illegal = req_addr_i[0];
            SizeWord: req_illegal = (req_addr_i[1:0] != 2'b00);
            default:  req_illegal = 1'b1;
        endcase
    end

    // Lane selects and replicated write data. Replication lets both
    // lane-positioned and right-justified slaves pick up the store data.
    always_comb begin
        req_sel = 4'b1111;
        req_dat = req_wdata_i;
        case (req_size_i)
            SizeByte: begin
                req_sel = 4'b0001 << req_addr_i[1:0];
                req_dat = {(XLEN/8){req_wdata_i[7:0]}};
            end
            SizeHalf: begin
                req_sel = req_addr_i[1] ? 4'b1100 : 4'b0011;
                req_dat = {(XLEN/16){req_wdata_i[15:0]}};
            end
            default: begin
                req_sel = 4'b1111;
                req_dat = req_wdata_i;
            end
        endcase
    end

    assign load_data = extend_load(size_q, unsigned_q, dat_i);

`ifdef WB_TIMEOUT_EN
    localparam int CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CntW-1:0] wdog_q;

    // Counts BUS cycles; it is zero on the first BUS cycle because it is
    // held clear in every other state.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wdog_q <= '0;
        end else if (state_q != BUS) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + CntW'(1);
        end
    end

    // Expiry on the TIMEOUT_CYCLES-th BUS edge, so cyc_o is high exactly
    // TIMEOUT_CYCLES cycles before dropping.
    assign timeout_hit = (state_q == BUS) && (wdog_q == CntW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and registered-output logic. Response flags default low so
    // rsp_valid_o is a single-cycle pulse; everything else holds by default.
    always_comb begin
        state_d       = state_q;
        adr_d         = adr_o;
        dat_d         = dat_o;
        sel_d         = sel_o;
        we_d          = we_o;
        cyc_d         = cyc_o;
        stb_d         = stb_o;
        size_d        = size_q;
        unsigned_d    = unsigned_q;
        rsp_rdata_d   = rsp_rdata_o;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (req_illegal) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d    = BUS;
                        adr_d      = req_addr_i[XLEN-1:2];
                        dat_d      = req_dat;
                        sel_d      = req_sel;
                        we_d       = req_we_i;
                        cyc_d      = 1'b1;
                        stb_d      = 1'b1;
                        size_d     = req_size_i;
                        unsigned_d = req_unsigned_i;
                    end
                end
            end

            BUS: begin
                // err_i beats ack_i; ack_i beats a simultaneous watchdog expiry.
                if (err_i) begin
                    state_d     = RESP;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else if (ack_i) begin
                    state_d     = RESP;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_o ? '0 : load_data;
                end else if (timeout_hit) begin
                    state_d       = RESP;
                    cyc_d         = 1'b0;
                    stb_d         = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset mid-cycle drops cyc_o/stb_o at the
    // reset edge and discards any pending response.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q       <= IDLE;
            adr_o         <= '0;
            dat_o         <= '0;
            sel_o         <= '0;
            we_o          <= 1'b0;
            cyc_o         <= 1'b0;
            stb_o         <= 1'b0;
            size_q        <= '0;
            unsigned_q    <= 1'b0;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
        end else begin
            state_q       <= state_d;
            adr_o         <= adr_d;
            dat_o         <= dat_d;
            sel_o         <= sel_d;
            we_o          <= we_d;
            cyc_o         <= cyc_d;
            stb_o         <= stb_d;
            size_q        <= size_d;
            unsigned_q    <= unsigned_d;
            rsp_valid_o   <= rsp_valid_d;
            rsp_rdata_o   <= rsp_rdata_d;
            rsp_err_o     <= rsp_err_d;
            rsp_timeout_o <= rsp_timeout_d;
        end
    end

endmodule

// File: tb/tb_wb_master_lsu.sv
// -----------------------------------------------------------------------------
// tb_wb_master_lsu
//
// Self-checking bench for wb_master_lsu: a table of directed transactions,
// randomized transactions checked against a behavioural model, and
// hand-written sequences for reset, stray acks, ignored requests and (when
// WB_TIMEOUT_EN is defined) the watchdog.
// -----------------------------------------------------------------------------
module tb_wb_master_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic [29:0] adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic [3:0]  sel_o;
    logic        we_o;
    logic        cyc_o;
    logic        stb_o;
    logic        ack_i;
    logic        err_i;

    int checks = 0;
    int errors = 0;

    // Slave response modes
    localparam int ModeAck  = 0;
    localparam int ModeErr  = 1;
    localparam int ModeBoth = 2;
    localparam int ModeNone = 3;

    // Observations of the most recent transaction
    logic [3:0]  obsSel;
    logic [31:0] obsDat;
    logic [29:0] obsAdr;
    logic        obsWe;
    int          cycCount;
    int          validCount;
    int          validAt;
    logic [31:0] obsRdata;
    logic        obsErr;
    logic        obsTimeout;
    bit          spamReq = 1'b0;

    wb_master_lsu #(
        .XLEN(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_we_i(req_we_i),
        .req_addr_i(req_addr_i),
        .req_size_i(req_size_i),
        .req_unsigned_i(req_unsigned_i),
        .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o),
        .adr_o(adr_o),
        .dat_o(dat_o),
        .dat_i(dat_i),
        .sel_o(sel_o),
        .we_o(we_o),
        .cyc_o(cyc_o),
        .stb_o(stb_o),
        .ack_i(ack_i),
        .err_i(err_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] rdIn;
        int          waitC;
        int          mode;
        logic        expBus;
        logic [3:0]  expSel;
        logic [31:0] expDat;
        logic [29:0] expAdr;
        logic        expErr;
        logic [31:0] expRdata;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic bit modelIllegal(input logic [1:0] size, input logic [31:0] addr);
        int bytes;
        if (size == 2'd3) return 1'b1;
        bytes = 1 << size;
        return (addr % bytes) != 0;
    endfunction

    function automatic logic [3:0] modelSel(input logic [1:0] size, input logic [31:0] addr);
        int bytes;
        int first;
        int mask;
        bytes = 1 << size;
        first = int'(addr % 4);
        mask  = (1 << bytes) - 1;
        return 4'(mask << first);
    endfunction

    function automatic logic [31:0] modelDat(input logic [1:0] size, input logic [31:0] wdata);
        if (size == 2'd0) return (wdata & 32'hFF) * 32'h0101_0101;
        if (size == 2'd1) return (wdata & 32'hFFFF) * 32'h0001_0001;
        return wdata;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [1:0] size, input logic uns,
                                              input logic [31:0] d);
        longint bits;
        longint value;
        if (size == 2'd2) return d;
        bits  = (size == 2'd0) ? 8 : 16;
        value = longint'(d) % (longint'(1) << bits);
        if (!uns && value >= (longint'(1) << (bits - 1)))
            value = value - (longint'(1) << bits);
        return value[31:0];
    endfunction

    // Drive one request and act as the slave for `window` cycles, recording
    // what the master does on both the bus and response sides.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] wdata,
                                 input logic [31:0] rdIn, input int waitCycles,
                                 input int mode, input int window);
        int guard = 0;
        while (!req_ready_o && guard < 20) begin
            @(posedge clk_i); #1;
            guard++;
        end
        checkOutput("ready before request", 32'(req_ready_o), 32'd1);
        req_we_i       = we;
        req_addr_i     = addr;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_wdata_i    = wdata;
        dat_i          = rdIn;
        req_valid_i    = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;

        obsSel = '0; obsDat = '0; obsAdr = '0; obsWe = 1'b0;
        cycCount = 0; validCount = 0; validAt = -1;
        obsRdata = '0; obsErr = 1'b0; obsTimeout = 1'b0;

        for (int i = 0; i < window; i++) begin
            if (cyc_o) begin
                if (cycCount == 0) begin
                    obsSel = sel_o; obsDat = dat_o; obsAdr = adr_o; obsWe = we_o;
                end
                cycCount++;
                if (mode != ModeNone && cycCount > waitCycles) begin
                    ack_i       = (mode == ModeAck || mode == ModeBoth);
                    err_i       = (mode == ModeErr || mode == ModeBoth);
                    req_valid_i = 1'b0;
                end else begin
                    req_valid_i = spamReq;
                end
            end else begin
                ack_i = 1'b0;
                err_i = 1'b0;
            end
            if (rsp_valid_o) begin
                validCount++;
                if (validCount == 1) begin
                    validAt    = i;
                    obsRdata   = rsp_rdata_o;
                    obsErr     = rsp_err_o;
                    obsTimeout = rsp_timeout_o;
                end
            end
            @(posedge clk_i); #1;
        end
        ack_i = 1'b0;
        err_i = 1'b0;
        req_valid_i = 1'b0;
    endtask

    task automatic verifyTxn(input string tag, input logic expBus, input logic [3:0] expSel,
                             input logic [31:0] expDat, input logic [29:0] expAdr,
                             input logic expWe, input int expCyc, input logic expErr,
                             input logic expTo, input logic [31:0] expRdata, input int expValidAt);
        checkOutput({tag, " valid pulses"}, 32'(validCount), 32'd1);
        checkOutput({tag, " valid latency"}, 32'(validAt), 32'(expValidAt));
        checkOutput({tag, " cyc cycles"}, 32'(cycCount), 32'(expCyc));
        checkOutput({tag, " err"}, 32'(obsErr), 32'(expErr));
        checkOutput({tag, " timeout"}, 32'(obsTimeout), 32'(expTo));
        checkOutput({tag, " rdata"}, obsRdata, expRdata);
        if (expBus) begin
            checkOutput({tag, " sel"}, 32'(obsSel), 32'(expSel));
            checkOutput({tag, " dat"}, obsDat, expDat);
            checkOutput({tag, " adr"}, 32'(obsAdr), 32'(expAdr));
            checkOutput({tag, " we"}, 32'(obsWe), 32'(expWe));
        end
    endtask

    vec_t vecs[12];

    initial begin
        int n;
        logic        rWe, rUns, bus, eErr;
        logic [1:0]  rSize;
        logic [31:0] rAddr, rWdata, rRd, eRd;
        int          rWait, rMode, sample;

        vecs[0]  = '{1'b0, 32'h0000_0103, 2'd0, 1'b0, 32'h0, 32'h0000_0080, 2, ModeAck,
                     1'b1, 4'b1000, 32'h0, 30'h40, 1'b0, 32'hFFFF_FF80};
        vecs[1]  = '{1'b1, 32'h0000_0010, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0, 0, ModeAck,
                     1'b1, 4'b1111, 32'hDEAD_BEEF, 30'h4, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0000_0002, 2'd1, 1'b1, 32'h0, 32'h0000_8001, 1, ModeAck,
                     1'b1, 4'b1100, 32'h0, 30'h0, 1'b0, 32'h0000_8001};
        vecs[3]  = '{1'b0, 32'h0000_0002, 2'd1, 1'b0, 32'h0, 32'h0000_8001, 1, ModeAck,
                     1'b1, 4'b1100, 32'h0, 30'h0, 1'b0, 32'hFFFF_8001};
        vecs[4]  = '{1'b0, 32'h0000_0005, 2'd1, 1'b0, 32'h0, 32'h1234_5678, 0, ModeAck,
                     1'b0, 4'b0000, 32'h0, 30'h0, 1'b1, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0040, 2'd3, 1'b0, 32'h0, 32'h1234_5678, 0, ModeAck,
                     1'b0, 4'b0000, 32'h0, 30'h0, 1'b1, 32'h0};
        vecs[6]  = '{1'b0, 32'h0000_0020, 2'd2, 1'b0, 32'h0BAD_F00D, 32'h1234_5678, 1, ModeBoth,
                     1'b1, 4'b1111, 32'h0BAD_F00D, 30'h8, 1'b1, 32'h0};
        vecs[7]  = '{1'b1, 32'h0000_0001, 2'd0, 1'b0, 32'h1234_56A5, 32'h0, 1, ModeErr,
                     1'b1, 4'b0010, 32'hA5A5_A5A5, 30'h0, 1'b1, 32'h0};
        vecs[8]  = '{1'b1, 32'h0000_0006, 2'd2, 1'b0, 32'h1111_2222, 32'h0, 0, ModeAck,
                     1'b0, 4'b0000, 32'h0, 30'h0, 1'b1, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_07F2, 2'd0, 1'b1, 32'h0, 32'hFFFF_FF9C, 0, ModeAck,
                     1'b1, 4'b0100, 32'h0, 30'h1FC, 1'b0, 32'h0000_009C};
        vecs[10] = '{1'b1, 32'h0000_0106, 2'd1, 1'b0, 32'hCAFE_1234, 32'h0, 2, ModeAck,
                     1'b1, 4'b1100, 32'h1234_1234, 30'h41, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 32'h0000_0000, 2'd1, 1'b0, 32'h0, 32'hABCD_7FFF, 0, ModeAck,
                     1'b1, 4'b0011, 32'h0, 30'h0, 1'b0, 32'h0000_7FFF};

        rst_i = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0;
        req_size_i = '0; req_unsigned_i = 1'b0; req_wdata_i = '0;
        dat_i = '0; ack_i = 1'b0; err_i = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("reset ready", 32'(req_ready_o), 32'd1);
        checkOutput("reset cyc", 32'(cyc_o), 32'd0);
        checkOutput("reset stb", 32'(stb_o), 32'd0);
        checkOutput("reset we", 32'(we_o), 32'd0);
        checkOutput("reset sel", 32'(sel_o), 32'd0);
        checkOutput("reset adr", 32'(adr_o), 32'd0);
        checkOutput("reset dat", dat_o, 32'd0);
        checkOutput("reset rsp_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("reset rsp_err", 32'(rsp_err_o), 32'd0);
        checkOutput("reset rsp_timeout", 32'(rsp_timeout_o), 32'd0);
        checkOutput("reset rdata", rsp_rdata_o, 32'd0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        // Directed table
        for (int v = 0; v < 12; v++) begin
            n = vecs[v].expBus ? vecs[v].waitC + 1 : 0;
            applyStimulus(vecs[v].we, vecs[v].addr, vecs[v].size, vecs[v].uns, vecs[v].wdata,
                          vecs[v].rdIn, vecs[v].waitC, vecs[v].mode, vecs[v].waitC + 5);
            verifyTxn($sformatf("vec%0d", v), vecs[v].expBus, vecs[v].expSel, vecs[v].expDat,
                      vecs[v].expAdr, vecs[v].we, n, vecs[v].expErr, 1'b0,
                      vecs[v].expRdata, n);
        end

        // Randomized transactions against the model
        for (int t = 0; t < 40; t++) begin
            rWe    = 1'($urandom_range(0, 1));
            rUns   = 1'($urandom_range(0, 1));
            rSize  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            rAddr  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (rSize == 2'd1) rAddr[0] = 1'b0;
                if (rSize == 2'd2) rAddr[1:0] = 2'b00;
            end
            rWdata = $urandom;
            rRd    = $urandom;
            rWait  = $urandom_range(0, 3);
            sample = $urandom_range(0, 9);
            rMode  = (sample < 8) ? ModeAck : ((sample == 8) ? ModeErr : ModeBoth);
            bus    = !modelIllegal(rSize, rAddr);
            eErr   = !bus || (rMode != ModeAck);
            eRd    = (bus && rMode == ModeAck && !rWe) ? modelLoad(rSize, rUns, rRd) : 32'h0;
            n      = bus ? rWait + 1 : 0;
            applyStimulus(rWe, rAddr, rSize, rUns, rWdata, rRd, rWait, rMode, rWait + 5);
            verifyTxn($sformatf("rand%0d", t), bus, modelSel(rSize, rAddr),
                      modelDat(rSize, rWdata), rAddr[31:2], rWe, n, eErr, 1'b0, eRd, n);
        end

        // Requests while busy are ignored, not queued
        spamReq = 1'b1;
        applyStimulus(1'b0, 32'h30, 2'd2, 1'b0, 32'h0, 32'h0000_0055, 3, ModeAck, 12);
        spamReq = 1'b0;
        verifyTxn("busy req", 1'b1, 4'hF, 32'h0, 30'hC, 1'b0, 4, 1'b0, 1'b0, 32'h55, 4);

        // Stray ack/err while idle
        ack_i = 1'b1; err_i = 1'b1;
        n = 0;
        repeat (3) begin
            @(posedge clk_i); #1;
            if (rsp_valid_o || cyc_o) n++;
        end
        ack_i = 1'b0; err_i = 1'b0;
        checkOutput("stray ack activity", 32'(n), 32'd0);
        checkOutput("stray ack ready", 32'(req_ready_o), 32'd1);

        // Reset while in BUS
        req_we_i = 1'b0; req_addr_i = 32'h80; req_size_i = 2'd2; req_unsigned_i = 1'b0;
        req_valid_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        checkOutput("midreset cyc before", 32'(cyc_o), 32'd1);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        checkOutput("midreset cyc", 32'(cyc_o), 32'd0);
        checkOutput("midreset stb", 32'(stb_o), 32'd0);
        checkOutput("midreset ready", 32'(req_ready_o), 32'd1);
        rst_i = 1'b1;
        n = 0;
        repeat (4) begin
            if (rsp_valid_o) n++;
            @(posedge clk_i); #1;
        end
        checkOutput("midreset no response", 32'(n), 32'd0);

`ifdef WB_TIMEOUT_EN
        // Watchdog expiry after 4 BUS cycles
        applyStimulus(1'b0, 32'h44, 2'd2, 1'b0, 32'h0, 32'h7777_7777, 0, ModeNone, 10);
        verifyTxn("timeout", 1'b1, 4'hF, 32'h0, 30'h11, 1'b0, 4, 1'b1, 1'b1, 32'h0, 4);
        // Ack on the expiry edge completes normally
        applyStimulus(1'b0, 32'h48, 2'd2, 1'b0, 32'h0, 32'h7777_7777, 3, ModeAck, 10);
        verifyTxn("ack at expiry", 1'b1, 4'hF, 32'h0, 30'h12, 1'b0, 4, 1'b0, 1'b0,
                  32'h7777_7777, 4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
